// File: rtl/edac_encode_4bit_seq.sv
// 4-bit EDAC encoder: nibble -> 16-bit codeword (data, 4-bit CRC, Hamming parity).
// CRC division runs one step per clock, then one Hamming cycle; valid/ready on both sides.
module edac_encode_4bit_seq #(
  parameter bit FIX_POLY_CHECK = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [3:0]  DIN,
  input  logic [3:0]  CRC_POLY,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] DOUT,
  output logic        busy,
  output logic        poly_err,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never drops and data never changes while waiting for ready.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV0 = 3'd1,
    S_DIV1 = 3'd2,
    S_DIV2 = 3'd3,
    S_DIV3 = 3'd4,
    S_HAM  = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  state_t      state_q;
  logic [7:0]  work_q;
  logic [7:0]  poly_q;
  logic [3:0]  data_q;
  logic [15:0] dout_q;
  logic        dout_valid_q;
  logic        din_ready_q;
  logic        poly_err_q;

  logic        div_bit;
  logic [7:0]  work_d;
  logic [15:0] codeword_d;
  logic [3:0]  crc;

  // The bit examined by each division step walks from 7 down to 4.
  always_comb begin
    div_bit = 1'b0;
    unique case (state_q)
      S_DIV0:  div_bit = work_q[7];
      S_DIV1:  div_bit = work_q[6];
      S_DIV2:  div_bit = work_q[5];
      S_DIV3:  div_bit = work_q[4];
      default: div_bit = 1'b0;
    endcase
    work_d = div_bit ? (work_q ^ poly_q) : work_q;
  end

  assign crc = work_q[3:0];

  always_comb begin
    codeword_d        = 16'h0000;
    codeword_d[11:8]  = data_q;
    codeword_d[6]     = crc[3];
    codeword_d[5]     = crc[2];
    codeword_d[4]     = crc[1];
    codeword_d[2]     = crc[0];
    codeword_d[0]     = codeword_d[2] ^ codeword_d[4] ^ codeword_d[6] ^ codeword_d[8] ^ codeword_d[10];
    codeword_d[1]     = codeword_d[2] ^ codeword_d[5] ^ codeword_d[6] ^ codeword_d[9] ^ codeword_d[10];
    codeword_d[3]     = codeword_d[4] ^ codeword_d[5] ^ codeword_d[6] ^ codeword_d[11];
    codeword_d[7]     = codeword_d[8] ^ codeword_d[9] ^ codeword_d[10] ^ codeword_d[11];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      work_q       <= 8'h00;
      poly_q       <= 8'h00;
      data_q       <= 4'h0;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b0;
      poly_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          din_ready_q <= 1'b1;
          if (din_valid && din_ready_q) begin
            data_q      <= DIN;
            work_q      <= {DIN, 4'b0000};
            poly_q      <= {CRC_POLY, 4'b0000};
            poly_err_q  <= FIX_POLY_CHECK && !CRC_POLY[3];
            din_ready_q <= 1'b0;
            state_q     <= S_DIV0;
          end
        end
        S_DIV0, S_DIV1, S_DIV2, S_DIV3: begin
          work_q  <= work_d;
          poly_q  <= poly_q >> 1;
          state_q <= (state_q == S_DIV3) ? S_HAM : state_t'(state_q + 3'd1);
        end
        S_HAM: begin
          dout_q       <= codeword_d;
          dout_valid_q <= 1'b1;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign din_ready   = din_ready_q;
  assign dout_valid  = dout_valid_q;
  assign DOUT        = dout_q;
  assign poly_err    = poly_err_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_edac_encode_4bit_seq.sv
// Bench for edac_encode_4bit_seq: directed codewords, backpressure, reset abort,
// exhaustive nibble sweep and random traffic checked by a queue-based scoreboard.
module tb_edac_encode_4bit_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [3:0]  DIN = 4'h0;
  logic [3:0]  CRC_POLY = 4'h0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [15:0] DOUT;
  logic        busy;
  logic        poly_err;
  logic [2:0]  dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];
  bit rand_ready = 1'b0;

  edac_encode_4bit_seq dut (
    .CLK(CLK), .RST(RST), .din_valid(din_valid), .din_ready(din_ready),
    .DIN(DIN), .CRC_POLY(CRC_POLY), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .DOUT(DOUT), .busy(busy), .poly_err(poly_err), .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Reference model: polynomial long division and positional Hamming coverage.
  function automatic logic [3:0] crc_ref(input logic [3:0] d, input logic [3:0] p);
    int w;
    w = int'(d) << 4;
    for (int k = 7; k >= 4; k--)
      if (((w >> k) & 1) != 0) w = w ^ (int'(p) << (k - 3));
    return 4'(w & 15);
  endfunction

  function automatic logic [15:0] code_ref(input logic [3:0] d, input logic [3:0] p);
    logic [15:0] cw;
    logic [3:0]  c;
    int pos;
    logic par;
    cw = 16'h0000;
    c = crc_ref(d, p);
    cw[11:8] = d;
    cw[2] = c[0]; cw[4] = c[1]; cw[5] = c[2]; cw[6] = c[3];
    for (int j = 0; j < 4; j++) begin
      pos = (1 << j) - 1;
      par = 1'b0;
      for (int i = 0; i < 12; i++)
        if (i != pos && (((i + 1) >> j) & 1) != 0) par = par ^ cw[i];
      cw[pos] = par;
    end
    return cw;
  endfunction

  function automatic logic [3:0] syndrome(input logic [15:0] cw);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 12; i++)
      if (cw[i]) s = s ^ 4'(i + 1);
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output is popped and compared.
  always @(negedge CLK) begin
    logic [16:0] e;
    if (!RST && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", DOUT);
      end else begin
        e = exp_q.pop_front();
        check("dout", DOUT, e[15:0]);
        check("poly_err", {15'd0, poly_err}, {15'd0, e[16]});
        check("syndrome", {12'd0, syndrome(DOUT)}, 16'h0000);
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
  end

  // Waits for din_ready, presents one word for the accept edge, returns 1 time unit after it.
  task automatic send(input logic [3:0] d, input logic [3:0] p, input bit push,
                      input bit use_const, input logic [16:0] const_exp);
    int n;
    n = 0;
    while (!din_ready && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    if (!din_ready) begin
      n_chk++; n_fail++;
      $display("FAIL din_ready_timeout: got 0 expected 1");
    end
    din_valid = 1'b1; DIN = d; CRC_POLY = p;
    if (push) begin
      if (use_const) exp_q.push_back(const_exp);
      else exp_q.push_back({!p[3], code_ref(d, p)});
    end
    @(posedge CLK); #1;
    din_valid = 1'b0;
    DIN = 4'($urandom);
    CRC_POLY = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge CLK); #1; n++;
    end
    n_chk++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int cnt;
    // Reset state
    #12;
    check("rst_dout", DOUT, 16'h0000);
    check("rst_flags", {11'd0, dout_valid, din_ready, busy, poly_err, 1'b0}, 16'h0000);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    check("din_ready_after_rst", {15'd0, din_ready}, 16'h0001);

    // 8/B with latency and hold-after-handshake
    dout_ready = 1'b1;
    send(4'h8, 4'hB, 1'b1, 1'b1, {1'b0, 16'h08DA});
    cnt = 0;
    while (!dout_valid && cnt < 20) begin
      @(posedge CLK); #1; cnt++;
    end
    check("latency", 16'(cnt), 16'd5);
    check("poly_err_8B", {15'd0, poly_err}, 16'h0000);
    @(posedge CLK); #1;
    check("dout_hold", DOUT, 16'h08DA);
    check("valid_drop", {14'd0, dout_valid, busy}, 16'h0000);

    // F/B under 20 cycles of backpressure with ignored input
    dout_ready = 1'b0;
    send(4'hF, 4'hB, 1'b1, 1'b1, {1'b0, 16'h0F70});
    cnt = 0;
    while (!dout_valid && cnt < 20) begin
      @(posedge CLK); #1; cnt++;
    end
    for (int i = 0; i < 20; i++) begin
      din_valid = 1'b1; DIN = 4'($urandom); CRC_POLY = 4'($urandom);
      @(posedge CLK); #1;
      check("bp_dout", DOUT, 16'h0F70);
      check("bp_flags", {14'd0, dout_valid, din_ready}, 16'h0002);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    drain();

    send(4'h0, 4'hB, 1'b1, 1'b1, {1'b0, 16'h0000});
    drain();

    // Non-monic polynomial sets poly_err, next good accept clears it
    send(4'hA, 4'h5, 1'b1, 1'b0, 17'h0);
    drain();
    check("poly_err_held", {15'd0, poly_err}, 16'h0001);
    send(4'h3, 4'hB, 1'b1, 1'b0, 17'h0);
    check("poly_err_cleared", {15'd0, poly_err}, 16'h0000);
    drain();

    // Reset in the middle of DIV1 discards the word
    send(4'h6, 4'hB, 1'b0, 1'b0, 17'h0);
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    check("midrst_dout", DOUT, 16'h0000);
    check("midrst_flags", {12'd0, dout_valid, din_ready, busy, poly_err}, 16'h0000);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    check("midrst_ready", {15'd0, din_ready}, 16'h0001);

    // Every nibble with two monic polynomials, back to back
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 16; d++)
        send(4'(d), (p == 0) ? 4'hB : 4'h9, 1'b1, 1'b0, 17'h0);
    drain();

    // Random traffic with random output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(4'($urandom), 4'($urandom), 1'b1, 1'b0, 17'h0);
    rand_ready = 1'b0;
    #2;
    dout_ready = 1'b1;
    drain();

    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (dout_valid) cnt++;
    end
    check("quiet", 16'(cnt), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
